// File: rtl/div1_run_ctrl.sv
// div1_run_ctrl: drives the CPU reciprocal run handshake and data memory,
// and checks the CPU result against a built-in restoring divider.
module div1_run_ctrl #(
  parameter int unsigned START_HOLD  = 2,
  parameter int unsigned INIT_HOLD   = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        go,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] expected,
  output logic [15:0] result_dut,
  output logic        dut_init,
  output logic        dut_start,
  input  logic        dut_ack,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wdata,
  input  logic [7:0]  dm_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_HI, S_WR_LO, S_START, S_INIT,
    S_RUN, S_RD_HI, S_RD_LO, S_WAIT_DIV, S_DONE
  } state_e;

  localparam logic [31:0] SH = 32'(START_HOLD);
  localparam logic [31:0] IH = 32'(INIT_HOLD);
  localparam logic [31:0] TO = 32'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [15:0] res_q, res_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [16:0] rem_sh;
  logic        accept;

  assign accept     = (state_q == S_IDLE) && go;
  assign pass       = pass_q;
  assign timeout    = tmo_q;
  assign result_dut = res_q;
  assign expected   = quo_q;

  // Control FSM: handshake sequencing, DM port and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    res_d     = res_q;
    busy      = 1'b1;
    done      = 1'b0;
    dut_init  = 1'b1;
    dut_start = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 8'd0;
    dm_wdata  = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          div_d   = divisor;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        dm_we     = 1'b1;
        dm_addr   = 8'd8;
        dm_wdata  = div_q[15:8];
        dut_start = 1'b1;
        state_d   = S_WR_LO;
      end
      S_WR_LO: begin
        dm_we     = 1'b1;
        dm_addr   = 8'd9;
        dm_wdata  = div_q[7:0];
        dut_start = 1'b1;
        cnt_d     = '0;
        if (SH != 0)      state_d = S_START;
        else if (IH != 0) state_d = S_INIT;
        else              state_d = S_RUN;
      end
      S_START: begin
        dut_start = 1'b1;
        if (cnt_q == SH - 32'd1) begin
          cnt_d   = '0;
          state_d = (IH != 0) ? S_INIT : S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_INIT: begin
        if (cnt_q == IH - 32'd1) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        dut_init = 1'b0;
        if (dut_ack) begin
          state_d = S_RD_HI;
        end else if (TO != 0 && cnt_q == TO - 32'd1) begin
          tmo_d   = 1'b1;
          res_d   = '0;
          state_d = S_WAIT_DIV;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RD_HI: begin
        dut_init    = 1'b0;
        dm_addr     = 8'd10;
        res_d[15:8] = dm_rdata;
        state_d     = S_RD_LO;
      end
      S_RD_LO: begin
        dut_init   = 1'b0;
        dm_addr    = 8'd11;
        res_d[7:0] = dm_rdata;
        state_d    = S_WAIT_DIV;
      end
      S_WAIT_DIV: begin
        dut_init = 1'b0;
        if (dcnt_q == 5'd0) begin
          pass_d  = (res_q == quo_q) && !tmo_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dut_init = 1'b0;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Restoring divider for 2^15 / divisor, one quotient bit per cycle
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dcnt_d = dcnt_q;
    rem_sh = {rem_q, quo_q[15]};
    if (accept) begin
      rem_d = '0;
      if (divisor == 16'd0) begin
        quo_d  = 16'hFFFF;
        dcnt_d = 5'd0;
      end else begin
        quo_d  = 16'h8000;
        dcnt_d = 5'd16;
      end
    end else if (dcnt_q != 5'd0) begin
      dcnt_d = dcnt_q - 5'd1;
      if (rem_sh >= {1'b0, div_q}) begin
        rem_d = 16'(rem_sh - {1'b0, div_q});
        quo_d = {quo_q[14:0], 1'b1};
      end else begin
        rem_d = rem_sh[15:0];
        quo_d = {quo_q[14:0], 1'b0};
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      res_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dcnt_q  <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_div1_run_ctrl.sv
// tb_div1_run_ctrl: randomized and directed runs against a
// cycle-timeline model of the handshake plus an arithmetic golden value.
module tb_div1_run_ctrl;

  localparam int SH = 2;
  localparam int IH = 2;
  localparam int TO = 50;
  localparam int L  = 2 + SH + IH;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        go = 1'b0;
  logic [15:0] divisor = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] expected, result_dut;
  logic        dut_init, dut_start;
  logic        dut_ack = 1'b0;
  logic        dm_we;
  logic [7:0]  dm_addr, dm_wdata, dm_rdata;

  logic [7:0]  mem [0:255];
  logic [15:0] cpu_res = '0;
  int          n_wr = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  div1_run_ctrl #(
    .START_HOLD(SH), .INIT_HOLD(IH), .TIMEOUT_CYC(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .go(go), .divisor(divisor),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .expected(expected), .result_dut(result_dut),
    .dut_init(dut_init), .dut_start(dut_start), .dut_ack(dut_ack),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  always #5 Clk = ~Clk;

  // CPU data memory: result bytes come from the CPU model
  always_comb begin
    if (dm_addr == 8'd10)      dm_rdata = cpu_res[15:8];
    else if (dm_addr == 8'd11) dm_rdata = cpu_res[7:0];
    else                       dm_rdata = mem[dm_addr];
  end

  // Record every DM write
  always @(posedge Clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
      n_wr <= n_wr + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] golden(input logic [15:0] d);
    if (d == 16'd0) return 16'hFFFF;
    return 16'(32'd32768 / {16'd0, d});
  endfunction

  // One launch; ack_dly<0 means the CPU never acks
  task automatic run_one(input logic [15:0] dv, input logic [15:0] ret,
                         input int ack_dly, input bit glitch,
                         input bit use_lit, input logic [15:0] lit);
    int w0;
    int ta;
    bit tmo;
    bit seen;
    logic [15:0] r_exp;
    w0 = n_wr;
    cpu_res = ret;
    seen = 1'b0;
    tmo = (ack_dly < 0) || (ack_dly >= TO);
    ta = tmo ? (L + TO - 1) : (L + ack_dly);
    @(negedge Clk);
    chk("idle_busy", busy, 0);
    go = 1'b1;
    divisor = dv;
    @(posedge Clk);
    #1;
    go = 1'b0;
    divisor = 16'($urandom);
    for (int t = 0; t < ta + 60; t++) begin
      @(negedge Clk);
      if (t < L) dut_ack = 1'($urandom_range(0, 1));
      else dut_ack = (!tmo && t >= L + ack_dly);
      go = glitch && (t == 3 || t == L + 1);
      if (glitch) divisor = 16'h1234;
      chk("busy", busy, 1);
      if (t < L) begin
        chk("pre_done", done, 0);
        chk("pre_we", dm_we, (t < 2) ? 1 : 0);
        chk("pre_init", dut_init, 1);
        chk("pre_start", dut_start, (t < 2 + SH) ? 1 : 0);
        if (t == 0) begin
          chk("wr_hi_addr", dm_addr, 8);
          chk("wr_hi_data", dm_wdata, dv[15:8]);
        end
        if (t == 1) begin
          chk("wr_lo_addr", dm_addr, 9);
          chk("wr_lo_data", dm_wdata, dv[7:0]);
        end
      end else begin
        chk("run_init", dut_init, 0);
        chk("run_start", dut_start, 0);
        chk("run_we", dm_we, 0);
        if (!tmo && t == ta + 1) chk("rd_hi_addr", dm_addr, 10);
        if (!tmo && t == ta + 2) chk("rd_lo_addr", dm_addr, 11);
        if (t <= ta + (tmo ? 1 : 3)) begin
          chk("early_done", done, 0);
        end else if (done) begin
          seen = 1'b1;
          r_exp = tmo ? 16'h0000 : ret;
          chk("expected", expected, golden(dv));
          if (use_lit) chk("expected_lit", expected, lit);
          chk("result_dut", result_dut, r_exp);
          chk("timeout", timeout, tmo);
          chk("pass", pass, (!tmo && r_exp == golden(dv)) ? 1 : 0);
          break;
        end
      end
    end
    chk("done_seen", seen, 1);
    dut_ack = 1'b0;
    go = 1'b0;
    @(negedge Clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_init", dut_init, 1);
    chk("hold_expected", expected, golden(dv));
    chk("hold_timeout", timeout, tmo);
    chk("writes", n_wr - w0, 2);
    chk("mem8", mem[8], dv[15:8]);
    chk("mem9", mem[9], dv[7:0]);
  endtask

  initial begin
    logic [15:0] dv;
    logic [15:0] ret;
    int ad;
    int dcount;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_expected", expected, 0);
    chk("rst_result", result_dut, 0);
    chk("rst_init", dut_init, 1);
    chk("rst_start", dut_start, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    @(negedge Clk);
    Reset = 1'b1;

    run_one(16'd4, 16'h2000, 10, 1'b0, 1'b1, 16'h2000);
    chk("pass_4", pass, 1);
    run_one(16'd400, 16'h0051, 10, 1'b0, 1'b1, 16'h0051);
    chk("pass_400", pass, 1);
    run_one(16'd400, 16'h0052, 3, 1'b0, 1'b1, 16'h0051);
    chk("fail_400", pass, 0);
    chk("res_400", result_dut, 16'h0052);
    run_one(16'd0, 16'hFFFF, 0, 1'b0, 1'b1, 16'hFFFF);
    chk("pass_0", pass, 1);
    run_one(16'd1, 16'h8000, 5, 1'b1, 1'b1, 16'h8000);
    chk("pass_1", pass, 1);
    run_one(16'hFFFF, 16'h0000, 12, 1'b0, 1'b1, 16'h0000);
    chk("pass_ffff", pass, 1);
    run_one(16'd300, 16'h1234, -1, 1'b0, 1'b1, 16'h006D);
    chk("tmo_pass", pass, 0);
    chk("tmo_res", result_dut, 0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) dv = 16'($urandom_range(0, 20));
      else dv = 16'($urandom);
      ad = $urandom_range(0, 55);
      ret = ($urandom_range(0, 1) == 1) ? golden(dv) : 16'($urandom);
      run_one(dv, ret, ad, 1'($urandom_range(0, 1)), 1'b0, 16'h0);
    end

    @(negedge Clk);
    go = 1'b1;
    divisor = 16'd77;
    @(posedge Clk);
    #1;
    go = 1'b0;
    repeat (L + 3) @(negedge Clk);
    chk("mid_run_init", dut_init, 0);
    Reset = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_init", dut_init, 1);
    chk("mr_start", dut_start, 0);
    chk("mr_done", done, 0);
    chk("mr_we", dm_we, 0);
    chk("mr_expected", expected, 0);
    chk("mr_result", result_dut, 0);
    chk("mr_pass", pass, 0);
    @(negedge Clk);
    Reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      if (done || busy) dcount++;
    end
    chk("mr_no_done", dcount, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div1_run_ctrl.md
Name: div1_run_ctrl

Overview:
- Hardware initiator for the CPU program-1 (reciprocal) run protocol; drives the CPU's init/start/ack handshake and its data-memory port.
- Loads the divisor into data memory bytes 8/9, launches the program, waits for ack, then reads the result from bytes 10/11.
- Computes the golden reciprocal with an internal iterative divider and flags pass/fail.
- Sits beside the CPU in an FPGA self-check wrapper; a host or button logic issues `go`.

Parameters:
- START_HOLD, 2, cycles `dut_start` stays high after the last DM write.
- INIT_HOLD, 2, further cycles `dut_init` stays high after `dut_start` falls.
- TIMEOUT_CYC, 4096, maximum RUN cycles waiting for `dut_ack`; 0 disables the timeout.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- go  in  1  launch request; sampled only in IDLE.
- divisor  in  16  operand; latched on accepted `go`.
- busy  out  1  high from accepted `go` until DONE.
- done  out  1  one-cycle pulse when the result and status are valid.
- pass  out  1  result_dut equals expected; valid from `done` until the next accepted `go`.
- timeout  out  1  ack never arrived; valid like `pass`.
- expected  out  16  golden result.
- result_dut  out  16  value read back from the CPU.
- dut_init  out  1  CPU reset, active-high.
- dut_start  out  1  CPU start.
- dut_ack  in  1  CPU program-complete flag.
- dm_we  out  1  data-memory write enable.
- dm_addr  out  8  data-memory address, shared by reads and writes.
- dm_wdata  out  8  write data.
- dm_rdata  in  8  read data; combinational, valid in the same cycle as `dm_addr`.

Behaviour:
- Reset (Reset=0, any state, takes effect immediately):
  - state IDLE; busy=0, done=0, pass=0, timeout=0.
  - expected=0, result_dut=0.
  - dut_init=1 (CPU held in reset), dut_start=0.
  - dm_we=0, dm_addr=0, dm_wdata=0.
  - Divider and counters cleared. Mid-run reset abandons the run and no `done` is issued.
- FSM states: IDLE, WR_HI, WR_LO, START, INIT, RUN, RD_HI, RD_LO, WAIT_DIV, DONE.
- IDLE:
  - dut_init=1, dut_start=0.
  - `go`=1 latches `divisor`, clears pass/timeout, starts the divider, sets busy and moves to WR_HI.
- WR_HI: dm_we=1, dm_addr=8, dm_wdata=divisor[15:8]; dut_init=1, dut_start=1.
- WR_LO: dm_we=1, dm_addr=9, dm_wdata=divisor[7:0]; dut_init=1, dut_start=1.
- START: START_HOLD cycles with dut_start=1, dut_init=1.
- INIT: INIT_HOLD cycles with dut_start=0, dut_init=1.
- RUN:
  - dut_init=0; the cycle counter starts at 0.
  - `dut_ack`=1 moves to RD_HI.
  - When the counter reaches TIMEOUT_CYC (if nonzero): timeout=1, result_dut=0, go to WAIT_DIV.
  - `dut_ack` is ignored in every state other than RUN.
- RD_HI: dm_addr=10, result_dut[15:8] ← dm_rdata.
- RD_LO: dm_addr=11, result_dut[7:0] ← dm_rdata.
- WAIT_DIV: stay until the divider is finished, then go to DONE.
- DONE:
  - For exactly one cycle: done=1, pass = (result_dut==expected) && !timeout.
  - Next cycle: IDLE, busy=0; dut_init returns to 1.
  - pass, timeout, expected and result_dut hold until the next accepted `go`.
- Golden value:
  - expected = floor(32768 / divisor), i.e. bits [63:48] of 2^63/divisor, truncated with no rounding.
  - divisor=0 gives expected=16'hFFFF (saturate); the divider is bypassed.
  - Restoring divider, 1 quotient bit per cycle, 17-bit dividend 2^15, 16 iterations.
  - Runs concurrently with WR_HI..RUN; `expected` is stable before DONE.
- `go` while busy is ignored; `go` held high across DONE starts a new run on the cycle the FSM re-enters IDLE.
- No DM write occurs outside WR_HI/WR_LO.
- Launch-to-RUN latency: 2 + START_HOLD + INIT_HOLD cycles.

Test Plan:
- divisor=4, CPU model acks 10 cycles after init falls and returns 16'h2000 → DM writes [8]=00,[9]=04; reads 10/11; expected=2000, pass=1, done pulses once.
- divisor=400, model returns 0051 → expected=0051, pass=1; model returns 0052 → pass=0, result_dut=0052.
- divisor=0, model returns FFFF → expected=FFFF, pass=1.
- divisor=1 → expected=8000; divisor=16'hFFFF → expected=0000; both pass when the model echoes them.
- TIMEOUT_CYC=50, model never acks → done at cycle 50 of RUN, timeout=1, pass=0, result_dut=0.
- Reset=0 asserted during RUN → immediate IDLE, dut_init=1, busy=0, no done; `go` pulsed during busy → ignored (single write pair observed).
